// File: rtl/mips_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit.
package mips_pkg;

  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC, S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP, S_TRAP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_B   = 2'd0;
  localparam logic [1:0] SRCB_4   = 2'd1;
  localparam logic [1:0] SRCB_IMM = 2'd2;
  localparam logic [1:0] SRCB_BR  = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

endpackage

// File: rtl/mips_alu_dec.sv
// R-type funct decoder: maps funct to an ALU operation and flags unsupported codes.
module mips_alu_dec
  import mips_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_ctrl,
  output logic       valid
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    valid    = 1'b1;
    case (funct)
      FN_ADD:  alu_ctrl = ALU_ADD;
      FN_SUB:  alu_ctrl = ALU_SUB;
      FN_AND:  alu_ctrl = ALU_AND;
      FN_OR:   alu_ctrl = ALU_OR;
      FN_SLT:  alu_ctrl = ALU_SLT;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control FSM: Moore strobes per state, memory ready handshake,
// retired-instruction counter and sticky illegal-instruction trap.
module mips_mc_ctrl
  import mips_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_ctrl,
  output logic [1:0]       pc_src,
  output logic             retire,
  output logic [CNT_W-1:0] instr_count,
  output logic             illegal
);

  state_t           state_reg, state_next;
  logic             is_bne_reg, is_sw_reg, illegal_reg;
  logic [CNT_W-1:0] count_reg;
  logic [2:0]       dec_alu_ctrl;
  logic             dec_valid;

  mips_alu_dec u_alu_dec (
    .funct    (funct),
    .alu_ctrl (dec_alu_ctrl),
    .valid    (dec_valid)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state_reg <= S_RST;
    else          state_reg <= state_next;
  end

  // Opcode is only looked at in DECODE; later states use these latched flags.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      is_bne_reg  <= 1'b0;
      is_sw_reg   <= 1'b0;
      illegal_reg <= 1'b0;
      count_reg   <= '0;
    end else begin
      if (state_reg == S_DECODE) begin
        is_bne_reg <= (opcode == OP_BNE);
        is_sw_reg  <= (opcode == OP_SW);
      end
      if (state_next == S_TRAP) illegal_reg <= 1'b1;
      if (retire) count_reg <= count_reg + CNT_W'(1);
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_RST:    state_next = S_FETCH;
      S_FETCH:  if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        if (opcode == OP_RTYPE)                        state_next = S_EXEC;
        else if (opcode == OP_LW || opcode == OP_SW)   state_next = S_MEMADR;
        else if (opcode == OP_BEQ || opcode == OP_BNE) state_next = S_BRANCH;
        else if (opcode == OP_ADDI)                    state_next = S_ADDIEX;
        else if (opcode == OP_J)                       state_next = S_JUMP;
        else                                           state_next = S_TRAP;
      end
      S_MEMADR: state_next = is_sw_reg ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) state_next = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_next = S_FETCH;
      S_EXEC:   state_next = dec_valid ? S_ALUWB : S_TRAP;
      S_ADDIEX: state_next = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: state_next = S_FETCH;
      S_TRAP:   state_next = S_TRAP;
      default:  state_next = S_RST;
    endcase
  end

  always_comb begin
    pc_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    alu_ctrl   = ALU_AND;
    pc_src     = PCSRC_ALU;
    retire     = 1'b0;
    case (state_reg)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_4;
        alu_ctrl  = ALU_ADD;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = SRCB_BR;
        alu_ctrl  = ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_ctrl  = ALU_ADD;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        retire    = mem_ready;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_ctrl  = dec_alu_ctrl;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_ctrl  = ALU_SUB;
        pc_src    = PCSRC_ALUOUT;
        pc_write  = is_bne_reg ? !zero : zero;
        retire    = 1'b1;
      end
      S_JUMP: begin
        pc_src   = PCSRC_JUMP;
        pc_write = 1'b1;
        retire   = 1'b1;
      end
      default: ;
    endcase
  end

  assign instr_count = count_reg;
  assign illegal     = illegal_reg;

endmodule
